// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - start/busy/done handshake and operand/result bundle for serial_subtractor
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow_out
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow_out
  );
endinterface

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial LSB-first unsigned subtractor, one full-subtractor stage
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input logic           clk,
  input logic           rst,
  serial_subtractor_if.slave bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic             accept;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-2:0] sr;
  logic [WIDTH-1:0] sr_next;
  logic             bf;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;
  logic             d;
  logic             bo;

  full_subtractor u_fs (
    .x  (sa[0]),
    .y  (sb[0]),
    .bi (bf),
    .d  (d),
    .bo (bo)
  );

  // The bit processed this edge lands in the MSB; the committed word is this vector.
  assign sr_next = {d, sr};

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = RUN;
          accept    = 1'b1;
        end
      end
      RUN: begin
        if (cnt == LAST) state_nxt = DONE;
      end
      DONE: begin
        if (bus.start) begin
          state_nxt = RUN;
          accept    = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sa       <= '0;
      sb       <= '0;
      sr       <= '0;
      bf       <= 1'b0;
      cnt      <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else if (accept) begin
      sa  <= bus.a;
      sb  <= bus.b;
      bf  <= 1'b0;
      cnt <= '0;
    end else if (state == RUN) begin
      sa <= sa >> 1;
      sb <= sb >> 1;
      sr <= sr_next[WIDTH-1:1];
      bf <= bo;
      if (cnt == LAST) begin
        diff_q   <= sr_next;
        borrow_q <= bo;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign bus.busy       = (state == RUN);
  assign bus.done       = (state == DONE);
  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrow_q;
endmodule

// d = x ^ y ^ bi ; bo = ~x&y | ~(x^y)&bi, inversions done with tied-input nands.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);
  logic xy;
  logic nx;
  logic nxy;
  logic g_gen;
  logic g_prop;

  xor_gate u_x0 (.a(x),  .b(y),  .y(xy));
  xor_gate u_x1 (.a(xy), .b(bi), .y(d));
  nand     u_n0 (nx,  x,  x);
  nand     u_n1 (nxy, xy, xy);
  and_gate u_a0 (.a(nx),  .b(y),  .y(g_gen));
  and_gate u_a1 (.a(nxy), .b(bi), .y(g_prop));
  or_gate  u_o0 (.a(g_gen), .b(g_prop), .y(bo));
endmodule

module xor_gate (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a ^ b;
endmodule

module and_gate (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a & b;
endmodule

module or_gate (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a | b;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - vector table, corner sequences and scoreboard for serial_subtractor
module tb_serial_subtractor;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(8)) bus8 ();
  serial_subtractor_if #(.WIDTH(5)) bus5 ();

  serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
  serial_subtractor #(.WIDTH(5)) dut5 (.clk(clk), .rst(rst), .bus(bus5.slave));

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] d;
    logic       bo;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    logic       bo;
  } exp_t;

  exp_t q8[$];
  exp_t q5[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b0 && bus8.done === 1'b1) begin
      if (q8.size() == 0) chk("unexpected_done8", 1, 0);
      else begin
        e = q8.pop_front();
        chk("sb_diff8", {24'd0, bus8.diff}, {24'd0, e.d});
        chk("sb_borrow8", {31'd0, bus8.borrow_out}, {31'd0, e.bo});
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b0 && bus5.done === 1'b1) begin
      if (q5.size() == 0) chk("unexpected_done5", 1, 0);
      else begin
        e = q5.pop_front();
        chk("sb_diff5", {27'd0, bus5.diff}, {27'd0, e.d[4:0]});
        chk("sb_borrow5", {31'd0, bus5.borrow_out}, {31'd0, e.bo});
      end
    end
  end

  task automatic push8(input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    e.d  = a - b;
    e.bo = (a < b);
    q8.push_back(e);
  endtask

  task automatic push5(input logic [4:0] a, input logic [4:0] b);
    exp_t e;
    logic [4:0] d5;
    d5   = a - b;
    e.d  = {3'd0, d5};
    e.bo = (a < b);
    q5.push_back(e);
  endtask

  // Returns at the negedge of the first RUN cycle.
  task automatic launch8(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    bus8.a     = a;
    bus8.b     = b;
    bus8.start = 1'b1;
    push8(a, b);
    @(negedge clk);
    bus8.start = 1'b0;
  endtask

  // k counts RUN-side cycles (1 = first RUN cycle) up to and including the done cycle.
  task automatic run_to_done8(output int k, output int nbusy);
    k     = 1;
    nbusy = 0;
    while (bus8.done !== 1'b1 && k < 40) begin
      if (bus8.busy === 1'b1) nbusy++;
      @(negedge clk);
      k++;
    end
    if (bus8.done !== 1'b1) chk("timeout8", 0, 1);
  endtask

  vec_t vecs[6];

  initial begin
    int k, nb, t, t1, t2, nlow, nd;
    logic [7:0] ra, rb;
    logic [4:0] ra5, rb5;

    vecs[0] = '{8'h5A, 8'h3C, 8'h1E, 1'b0};
    vecs[1] = '{8'h03, 8'h05, 8'hFE, 1'b1};
    vecs[2] = '{8'h00, 8'hFF, 8'h01, 1'b1};
    vecs[3] = '{8'hA7, 8'hA7, 8'h00, 1'b0};
    vecs[4] = '{8'hFF, 8'h00, 8'hFF, 1'b0};
    vecs[5] = '{8'h00, 8'h01, 8'hFF, 1'b1};

    rst = 1'b1;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0;
    bus5.start = 1'b0; bus5.a = '0; bus5.b = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, bus8.busy}, 0);
    chk("rst_done", {31'd0, bus8.done}, 0);
    chk("rst_diff", {24'd0, bus8.diff}, 0);
    chk("rst_borrow", {31'd0, bus8.borrow_out}, 0);
    rst = 1'b0;

    // Latency and hold on the first operation.
    launch8(8'h5A, 8'h3C);
    run_to_done8(k, nb);
    chk("busy_cycles", nb, 8);
    chk("done_cycle", k, 9);
    chk("done_busy_excl", {31'd0, bus8.busy}, 0);
    repeat (3) @(negedge clk);
    chk("hold_diff", {24'd0, bus8.diff}, 32'h1E);
    chk("hold_borrow", {31'd0, bus8.borrow_out}, 0);
    chk("idle_busy", {31'd0, bus8.busy}, 0);
    chk("idle_done", {31'd0, bus8.done}, 0);

    for (int i = 0; i < 6; i++) begin
      launch8(vecs[i].a, vecs[i].b);
      run_to_done8(k, nb);
      chk("tbl_diff", {24'd0, bus8.diff}, {24'd0, vecs[i].d});
      chk("tbl_borrow", {31'd0, bus8.borrow_out}, {31'd0, vecs[i].bo});
    end

    // start during RUN is ignored.
    launch8(8'h80, 8'h01);
    repeat (2) @(negedge clk);
    bus8.a = 8'hFF; bus8.b = 8'hFF; bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    run_to_done8(k, nb);
    chk("ign_diff", {24'd0, bus8.diff}, 32'h7F);
    chk("ign_borrow", {31'd0, bus8.borrow_out}, 0);

    // Back-to-back with start held through the DONE cycle.
    @(negedge clk);
    bus8.a = 8'h10; bus8.b = 8'h20; bus8.start = 1'b1;
    push8(8'h10, 8'h20);
    t = 0; t1 = -1; t2 = -1; nlow = 0;
    while (t2 < 0 && t < 60) begin
      @(negedge clk);
      t++;
      if (bus8.done === 1'b1) begin
        if (t1 < 0) begin
          t1 = t;
          chk("b2b_diff0", {24'd0, bus8.diff}, 32'hF0);
          bus8.a = 8'h20; bus8.b = 8'h10;
          push8(8'h20, 8'h10);
        end else begin
          t2 = t;
        end
      end else if (bus8.busy !== 1'b1) begin
        nlow++;
      end
    end
    bus8.start = 1'b0;
    chk("b2b_first_done", t1, 9);
    chk("b2b_period", t2 - t1, 9);
    chk("b2b_busy_low", nlow, 0);
    chk("b2b_diff1", {24'd0, bus8.diff}, 32'h10);

    // Reset in the middle of RUN aborts without a done pulse.
    @(negedge clk);
    bus8.a = 8'h12; bus8.b = 8'h34; bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy", {31'd0, bus8.busy}, 0);
    chk("mid_rst_done", {31'd0, bus8.done}, 0);
    chk("mid_rst_diff", {24'd0, bus8.diff}, 0);
    chk("mid_rst_borrow", {31'd0, bus8.borrow_out}, 0);
    nd = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus8.done === 1'b1) nd++;
    end
    chk("no_done_after_rst", nd, 0);
    launch8(8'h12, 8'h34);
    run_to_done8(k, nb);
    chk("post_rst_diff", {24'd0, bus8.diff}, 32'hDE);
    chk("post_rst_borrow", {31'd0, bus8.borrow_out}, 1);

    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      launch8(ra, rb);
      run_to_done8(k, nb);
    end

    for (int i = 0; i < 1000; i++) begin
      ra5 = 5'($urandom);
      rb5 = 5'($urandom);
      @(negedge clk);
      bus5.a = ra5; bus5.b = rb5; bus5.start = 1'b1;
      push5(ra5, rb5);
      @(negedge clk);
      bus5.start = 1'b0;
      k = 1;
      while (bus5.done !== 1'b1 && k < 30) begin
        @(negedge clk);
        k++;
      end
      if (bus5.done !== 1'b1) chk("timeout5", 0, 1);
    end

    @(negedge clk);
    chk("q8_drained", q8.size(), 0);
    chk("q5_drained", q5.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
